// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//   DLX instruction-fetch stage plus the IF/ID pipeline register. Owns the PC,
//   runs a request/ready handshake to instruction memory, absorbs a decode
//   stall with a one-entry skid buffer and squashes wrong-path fetches when a
//   branch/jump redirect is resolved.
//
//   Bit numbering: the DLX documentation numbers bits big-endian ([0:31], bit 0
//   is the MSB). Here vectors are declared [31:0]; numeric values are identical,
//   so DLX bit k corresponds to bit (31-k). OpCode is the top six bits of the
//   instruction, Function the bottom six, and the word-aligned low bits are
//   [1:0].
//
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   Stall       in   decode cannot accept; freeze IF/ID
//   Redirect    in   taken branch/jump resolved; flush and refetch
//   RedirectPC  in   redirect target, low two bits ignored
//   IReq        out  instruction-memory request
//   IAddr       out  fetch address, always word aligned
//   IReady      in   memory accepts the request and returns IData this cycle
//   IData       in   fetched word, valid when IReq & IReady
//   InstrValid  out  IF/ID holds a real instruction
//   Instr       out  IF/ID instruction
//   OpCode      out  opcode field of Instr
//   Function    out  function field of Instr
//   PCPlus4     out  fetch PC + 4 of the IF/ID instruction (link value)
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  output logic        IReq,
  output logic [31:0] IAddr,
  input  logic        IReady,
  input  logic [31:0] IData,
  output logic        InstrValid,
  output logic [31:0] Instr,
  output logic [5:0]  OpCode,
  output logic [5:0]  Function,
  output logic [31:0] PCPlus4
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned FW   = 6;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   pend_pc_q, pend_pc_d;
  logic [XLEN-1:0]   buf_instr_q, buf_instr_d;
  logic [XLEN-1:0]   buf_pc4_q, buf_pc4_d;
  logic              buf_valid_q, buf_valid_d;
  logic              if_valid_q, if_valid_d;
  logic [XLEN-1:0]   if_instr_q, if_instr_d;
  logic [XLEN-1:0]   if_pc4_q, if_pc4_d;
  logic              ireq_q, ireq_d;

  logic              accept_c;
  logic [XLEN-1:0]   redirect_pc_c;
  logic [XLEN-1:0]   pc_plus4_c;
  logic              unused_redirect_lsb;

  // Low target bits are forced to zero; keep them visibly consumed.
  assign unused_redirect_lsb = ^RedirectPC[1:0];

  assign accept_c      = ireq_q & IReady;
  assign redirect_pc_c = {RedirectPC[XLEN-1:2], 2'b00};
  assign pc_plus4_c    = pc_q + XLEN'(4);

  // Next-state and IF/ID update logic.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_pc_d   = pend_pc_q;
    buf_instr_d = buf_instr_q;
    buf_pc4_d   = buf_pc4_q;
    buf_valid_d = buf_valid_q;
    if_valid_d  = if_valid_q;
    if_instr_d  = if_instr_q;
    if_pc4_d    = if_pc4_q;

    case (state_q)
      ST_BOOT: begin
        state_d = ST_FETCH;
        if (Redirect) begin
          pc_d = redirect_pc_c;
        end
      end

      ST_FETCH: begin
        if (Redirect) begin
          if (accept_c) begin
            pc_d = redirect_pc_c;
          end else begin
            // Request is outstanding: finish it before fetching the target.
            pend_pc_d = redirect_pc_c;
            state_d   = ST_DRAIN;
          end
        end else if (accept_c) begin
          pc_d = pc_plus4_c;
          if (Stall) begin
            buf_valid_d = 1'b1;
            buf_instr_d = IData;
            buf_pc4_d   = pc_plus4_c;
            state_d     = ST_HOLD;
          end else begin
            if_valid_d = 1'b1;
            if_instr_d = IData;
            if_pc4_d   = pc_plus4_c;
          end
        end
      end

      ST_HOLD: begin
        if (Redirect) begin
          pc_d    = redirect_pc_c;
          state_d = ST_FETCH;
        end else if (!Stall) begin
          if_valid_d  = buf_valid_q;
          if_instr_d  = buf_instr_q;
          if_pc4_d    = buf_pc4_q;
          buf_valid_d = 1'b0;
          state_d     = ST_FETCH;
        end
      end

      ST_DRAIN: begin
        // IAddr stays on the squashed address; returned data is dropped.
        if (Redirect) begin
          if (accept_c) begin
            pc_d    = redirect_pc_c;
            state_d = ST_FETCH;
          end else begin
            pend_pc_d = redirect_pc_c;
          end
        end else if (accept_c) begin
          pc_d    = pend_pc_q;
          state_d = ST_FETCH;
        end
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase

    // Redirect flushes IF/ID and the skid buffer in every state.
    if (Redirect) begin
      if_valid_d  = 1'b0;
      if_instr_d  = NOP_INSTR;
      if_pc4_d    = '0;
      buf_valid_d = 1'b0;
    end

    ireq_d = (state_d == ST_FETCH) || (state_d == ST_DRAIN);
  end

  // State and pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_BOOT;
      pc_q        <= RESET_PC;
      pend_pc_q   <= RESET_PC;
      buf_instr_q <= NOP_INSTR;
      buf_pc4_q   <= '0;
      buf_valid_q <= 1'b0;
      if_valid_q  <= 1'b0;
      if_instr_q  <= NOP_INSTR;
      if_pc4_q    <= '0;
      ireq_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_pc_q   <= pend_pc_d;
      buf_instr_q <= buf_instr_d;
      buf_pc4_q   <= buf_pc4_d;
      buf_valid_q <= buf_valid_d;
      if_valid_q  <= if_valid_d;
      if_instr_q  <= if_instr_d;
      if_pc4_q    <= if_pc4_d;
      ireq_q      <= ireq_d;
    end
  end

  // In DRAIN the PC still holds the squashed address, so IAddr is always pc_q.
  assign IReq       = ireq_q;
  assign IAddr      = pc_q;
  assign InstrValid = if_valid_q;
  assign Instr      = if_instr_q;
  assign OpCode     = if_instr_q[XLEN-1 -: FW];
  assign Function   = if_instr_q[FW-1:0];
  assign PCPlus4    = if_pc4_q;

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//   Self-checking bench for instr_fetch. A behavioural instruction memory
//   returns a word derived from the fetch address; every accepted fetch pushes
//   its expected IF/ID contents onto a scoreboard that scenario tasks pop and
//   compare when the instruction should appear.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        Stall = 1'b0;
  logic        Redirect = 1'b0;
  logic [31:0] RedirectPC = 32'h0;
  logic        IReq;
  logic [31:0] IAddr;
  logic        IReady = 1'b0;
  logic [31:0] IData;
  logic        InstrValid;
  logic [31:0] Instr;
  logic [5:0]  OpCode;
  logic [5:0]  Function;
  logic [31:0] PCPlus4;

  logic        use_fixed = 1'b0;
  logic [31:0] fixed_data = 32'h0;
  logic [31:0] exp_addr = 32'h0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  instr_fetch dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Stall     (Stall),
    .Redirect  (Redirect),
    .RedirectPC(RedirectPC),
    .IReq      (IReq),
    .IAddr     (IAddr),
    .IReady    (IReady),
    .IData     (IData),
    .InstrValid(InstrValid),
    .Instr     (Instr),
    .OpCode    (OpCode),
    .Function  (Function),
    .PCPlus4   (PCPlus4)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // Instruction memory: combinational read of the requested address.
  always_comb IData = use_fixed ? fixed_data : word_of(IAddr);

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Advance one cycle; an accepted, kept fetch enqueues its expected IF/ID value.
  task automatic adv(input bit keep);
    if (keep && IReq && IReady && !Redirect) begin
      sb.push_back('{word_of(exp_addr), exp_addr + 32'd4});
      exp_addr = exp_addr + 32'd4;
    end
    cyc();
  endtask

  function automatic exp_t pop_exp();
    exp_t e;
    if (sb.size() == 0) e = 'x;
    else e = sb.pop_front();
    return e;
  endfunction

  task automatic redirect_to(input logic [31:0] a);
    Redirect   = 1'b1;
    RedirectPC = a;
    IReady     = 1'b1;
    cyc();
    Redirect = 1'b0;
    sb.delete();
    exp_addr = {a[31:2], 2'b00};
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0; Stall = 1'b0; Redirect = 1'b0; IReady = 1'b1; use_fixed = 1'b0;
    exp_addr = 32'h0;
    repeat (2) cyc();
    checks++; if (IReq !== 1'b0) begin errors++; $display("FAIL reset_ireq got=%h exp=0", IReq); end
    checks++; if (IAddr !== 32'h0) begin errors++; $display("FAIL reset_iaddr got=%h exp=0", IAddr); end
    checks++; if (InstrValid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%h exp=0", InstrValid); end
    checks++; if (Instr !== 32'h0) begin errors++; $display("FAIL reset_instr got=%h exp=0", Instr); end
    checks++; if (PCPlus4 !== 32'h0) begin errors++; $display("FAIL reset_pc4 got=%h exp=0", PCPlus4); end
    #2 rst_n = 1'b1;
    checks++; if (IReq !== 1'b0) begin errors++; $display("FAIL boot_ireq got=%h exp=0", IReq); end
    adv(1'b1);
    checks++; if (IReq !== 1'b1 || IAddr !== 32'h0) begin errors++; $display("FAIL boot_addr0 got=%h/%h exp=1/0", IReq, IAddr); end
    checks++; if (InstrValid !== 1'b0) begin errors++; $display("FAIL boot_valid_early got=%h exp=0", InstrValid); end
    adv(1'b1);
    checks++; if (IAddr !== 32'h4) begin errors++; $display("FAIL boot_addr4 got=%h exp=4", IAddr); end
    e = pop_exp();
    checks++; if (InstrValid !== 1'b1 || PCPlus4 !== 32'h4 || Instr !== e.instr) begin
      errors++; $display("FAIL boot_first got=%h/%h/%h exp=1/%h/%h", InstrValid, Instr, PCPlus4, e.instr, 32'h4);
    end
    adv(1'b1);
    checks++; if (IAddr !== 32'h8) begin errors++; $display("FAIL boot_addr8 got=%h exp=8", IAddr); end
    e = pop_exp();
    checks++; if (Instr !== e.instr || PCPlus4 !== e.pc4) begin
      errors++; $display("FAIL boot_second got=%h/%h exp=%h/%h", Instr, PCPlus4, e.instr, e.pc4);
    end
  endtask

  task automatic test_latency();
    exp_t e;
    redirect_to(32'h100);
    IReady = 1'b0;
    checks++; if (InstrValid !== 1'b0) begin errors++; $display("FAIL lat_flush got=%h exp=0", InstrValid); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (IReq !== 1'b1 || IAddr !== 32'h100) begin
        errors++; $display("FAIL lat_hold_addr cyc=%0d got=%h/%h exp=1/100", i, IReq, IAddr);
      end
      if (i < 3) adv(1'b1);
    end
    use_fixed = 1'b1; fixed_data = 32'h2022_0005; IReady = 1'b1;
    sb.push_back('{32'h2022_0005, 32'h104});
    exp_addr = 32'h104;
    cyc();
    use_fixed = 1'b0;
    e = pop_exp();
    checks++; if (OpCode !== 6'h08 || Function !== 6'h05) begin
      errors++; $display("FAIL lat_fields got=%h/%h exp=08/05", OpCode, Function);
    end
    checks++; if (Instr !== e.instr || PCPlus4 !== e.pc4 || InstrValid !== 1'b1) begin
      errors++; $display("FAIL lat_ifid got=%h/%h/%h exp=1/%h/%h", InstrValid, Instr, PCPlus4, e.instr, e.pc4);
    end
    checks++; if (IAddr !== 32'h104) begin errors++; $display("FAIL lat_next got=%h exp=104", IAddr); end
  endtask

  task automatic test_stall_skid();
    exp_t e;
    redirect_to(32'h1FC);
    IReady = 1'b1;
    adv(1'b1);
    e = pop_exp();
    checks++; if (Instr !== e.instr || IAddr !== 32'h200) begin
      errors++; $display("FAIL skid_pre got=%h/%h exp=%h/200", Instr, IAddr, e.instr);
    end
    Stall = 1'b1;
    adv(1'b1);
    for (int i = 0; i < 3; i++) begin
      checks++; if (IReq !== 1'b0) begin errors++; $display("FAIL skid_ireq cyc=%0d got=%h exp=0", i, IReq); end
      checks++; if (Instr !== word_of(32'h1FC) || PCPlus4 !== 32'h200 || InstrValid !== 1'b1) begin
        errors++; $display("FAIL skid_frozen cyc=%0d got=%h/%h exp=%h/200", i, Instr, PCPlus4, word_of(32'h1FC));
      end
      if (i == 2) Stall = 1'b0;
      adv(1'b1);
    end
    e = pop_exp();
    checks++; if (Instr !== e.instr || PCPlus4 !== 32'h204 || InstrValid !== 1'b1) begin
      errors++; $display("FAIL skid_release got=%h/%h exp=%h/204", Instr, PCPlus4, e.instr);
    end
    checks++; if (IReq !== 1'b1 || IAddr !== 32'h204) begin
      errors++; $display("FAIL skid_next got=%h/%h exp=1/204", IReq, IAddr);
    end
  endtask

  task automatic test_redirect_pending();
    exp_t e;
    redirect_to(32'h2FC);
    IReady = 1'b1;
    adv(1'b1);
    e = pop_exp();
    checks++; if (Instr !== e.instr || InstrValid !== 1'b1) begin
      errors++; $display("FAIL pend_pre got=%h exp=%h", Instr, e.instr);
    end
    IReady = 1'b0; Redirect = 1'b1; RedirectPC = 32'h1003;
    cyc();
    Redirect = 1'b0;
    checks++; if (InstrValid !== 1'b0 || Instr !== 32'h0 || PCPlus4 !== 32'h0) begin
      errors++; $display("FAIL pend_flush got=%h/%h/%h exp=0/0/0", InstrValid, Instr, PCPlus4);
    end
    checks++; if (IReq !== 1'b1 || IAddr !== 32'h300) begin
      errors++; $display("FAIL pend_drain_addr got=%h/%h exp=1/300", IReq, IAddr);
    end
    cyc();
    checks++; if (IAddr !== 32'h300) begin errors++; $display("FAIL pend_drain_hold got=%h exp=300", IAddr); end
    IReady = 1'b1;
    cyc();
    exp_addr = 32'h1000;
    checks++; if (IReq !== 1'b1 || IAddr !== 32'h1000) begin
      errors++; $display("FAIL pend_target got=%h/%h exp=1/1000", IReq, IAddr);
    end
    checks++; if (InstrValid !== 1'b0) begin errors++; $display("FAIL pend_discard got=%h exp=0", InstrValid); end
    adv(1'b1);
    e = pop_exp();
    checks++; if (Instr !== e.instr || PCPlus4 !== 32'h1004) begin
      errors++; $display("FAIL pend_first got=%h/%h exp=%h/1004", Instr, PCPlus4, e.instr);
    end
  endtask

  task automatic test_redirect_stall();
    exp_t e;
    redirect_to(32'h400);
    IReady = 1'b1; Stall = 1'b1;
    adv(1'b1);
    checks++; if (IReq !== 1'b0) begin errors++; $display("FAIL rs_hold got=%h exp=0", IReq); end
    redirect_to(32'h500);
    checks++; if (InstrValid !== 1'b0 || Instr !== 32'h0) begin
      errors++; $display("FAIL rs_flush got=%h/%h exp=0/0", InstrValid, Instr);
    end
    checks++; if (IReq !== 1'b1 || IAddr !== 32'h500) begin
      errors++; $display("FAIL rs_target got=%h/%h exp=1/500", IReq, IAddr);
    end
    Stall = 1'b0; IReady = 1'b0;
    adv(1'b1);
    checks++; if (InstrValid !== 1'b0) begin errors++; $display("FAIL rs_buf_cleared got=%h exp=0", InstrValid); end
    IReady = 1'b1;
    adv(1'b1);
    e = pop_exp();
    checks++; if (Instr !== e.instr || PCPlus4 !== 32'h504 || IAddr !== 32'h504) begin
      errors++; $display("FAIL rs_first got=%h/%h/%h exp=%h/504/504", Instr, PCPlus4, IAddr, e.instr);
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    redirect_to(32'hFFFF_FFFC);
    IReady = 1'b1;
    checks++; if (IAddr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr got=%h exp=fffffffc", IAddr); end
    adv(1'b1);
    e = pop_exp();
    checks++; if (PCPlus4 !== 32'h0 || Instr !== e.instr || InstrValid !== 1'b1) begin
      errors++; $display("FAIL wrap_pc4 got=%h/%h exp=0/%h", PCPlus4, Instr, e.instr);
    end
    checks++; if (IAddr !== 32'h0) begin errors++; $display("FAIL wrap_next got=%h exp=0", IAddr); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic took;
    redirect_to(32'h800);
    for (int i = 0; i < 40; i++) begin
      IReady = 1'($urandom_range(0, 1));
      checks++; if (IAddr !== exp_addr || IReq !== 1'b1) begin
        errors++; $display("FAIL b2b_addr cyc=%0d got=%h exp=%h", i, IAddr, exp_addr);
      end
      took = IReady;
      adv(1'b1);
      if (took) begin
        e = pop_exp();
        checks++; if (Instr !== e.instr || PCPlus4 !== e.pc4 || InstrValid !== 1'b1) begin
          errors++; $display("FAIL b2b_ifid cyc=%0d got=%h/%h exp=%h/%h", i, Instr, PCPlus4, e.instr, e.pc4);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    IReady = 1'b0;
    checks++; if (IReq !== 1'b1) begin errors++; $display("FAIL rmid_pre got=%h exp=1", IReq); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (IReq !== 1'b0 || IAddr !== 32'h0 || InstrValid !== 1'b0) begin
      errors++; $display("FAIL rmid_async got=%h/%h/%h exp=0/0/0", IReq, IAddr, InstrValid);
    end
    cyc();
    #2 rst_n = 1'b1;
    cyc();
    checks++; if (IReq !== 1'b1 || IAddr !== 32'h0) begin
      errors++; $display("FAIL rmid_reboot got=%h/%h exp=1/0", IReq, IAddr);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_latency();
    test_stall_skid();
    test_redirect_pending();
    test_redirect_stall();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
